extra_hdr_noc_ctrl_to_data: RTL and testbench
=============================================

// Module: extra_hdr_noc_ctrl_to_data
// PURPOSE
//  Reassembles a narrow ctrl-NoC header message into one wide data-NoC header flit carrying EXTRA_W extra bits.
//  Ctrl message layout: routing flit, then misc flit, then EXTRA_FLITS payload flits, MSB chunk first.
//  Sits at a ctrl-NoC endpoint feeding a data-NoC consumer that expects extra-header fields in the header flit.
// PARAMETERS
//  EXTRA_W  96  width of the extra header field; must be >0 (elaboration error otherwise).
//  Derived: EXTRA_FLITS = ceil(EXTRA_W / CTRL_NOC1_DATA_W).
//  Derived: SAVE_W = EXTRA_FLITS * CTRL_NOC1_DATA_W; PADDING_W = SAVE_W - EXTRA_W.
//  Derived: counter width = max(1, $clog2(EXTRA_FLITS)).
// PORTS
//  clk               in   1                  clock
//  rst               in   1                  synchronous reset, active high
//  src_noc_ctd_val   in   1                  narrow flit valid
//  src_noc_ctd_data  in   CTRL_NOC1_DATA_W   narrow flit
//  noc_ctd_src_rdy   out  1                  narrow flit accepted when val&rdy
//  noc_ctd_dst_val   out  1                  wide header flit valid
//  noc_ctd_dst_data  out  NOC_DATA_WIDTH     wide header flit (beehive_noc_hdr_flit)
//  dst_noc_ctd_rdy   in   1                  downstream ready
//  ctd_len_err       out  1                  sticky msg_len mismatch flag; tied 0 unless the macro is defined
// BEHAVIOUR
//  Clocking and reset
//  - One clock, clk; reset rst is synchronous, active high.
//  - Reset: state=RTE_FLIT, noc_ctd_src_rdy=1, noc_ctd_dst_val=0, ctd_len_err=0, header/extra registers cleared to 0.
//  - A reset asserted mid-message discards all partial state. The next accepted flit is treated as a routing flit.
//  State machine (flits are transferred on val&rdy)
//  - RTE_FLIT: src_rdy=1. On xfer, latch routing fields into wide header bits [NOC_DATA_WIDTH-1 -: CTRL_NOC1_DATA_W].
//    Then force the wide msg_len to 0 (single-flit data msg), load extra counter=EXTRA_FLITS-1, go to MISC_FLIT.
//  - MISC_FLIT: src_rdy=1. On xfer, copy src_chip_id, src_x_coord, src_y_coord, src_fbits into hdr.core.core.src_*.
//    Ignore metadata_flits. Go to EXTRA_FLITS.
//  - EXTRA_FLITS: src_rdy=1. On xfer, shift flit into SAVE_W register from LSB side (first flit ends in MSBs).
//    Decrement the counter. On counter==0 xfer, go to OUTPUT.
//  - OUTPUT: src_rdy=0, dst_val=1. Data is fully registered; no combinational path from src to dst.
//    On dst_rdy, go to RTE_FLIT.
//  Output packing and timing
//  - Output field placement: noc_ctd_dst_data[NOC_DATA_WIDTH-BASE_FLIT_W-1 -: EXTRA_W] = save_reg[SAVE_W-1 -: EXTRA_W].
//    Padding LSBs are dropped. All bits below the extra field are 0.
//  - Latency: dst_val rises the cycle after the last extra flit is accepted.
//    Throughput is 1 message per (3+EXTRA_FLITS) cycles with no backpressure.
//  - Backpressure: dst_val and dst_data are held stable while OUTPUT && !dst_rdy. Input stalls (src_rdy=0) meanwhile.
//  - src_val low in any collecting state: state holds, no register changes.
//  - EXTRA_FLITS==1: EXTRA_FLITS state is entered once, counter is already 0, and the state exits on the first xfer.
// CONFIGURATION
//  Macro EXTRA_HDR_CTD_LEN_CHECK_EN.
//  Defined:
//  - On the RTE_FLIT xfer, compare incoming msg_len with 1+EXTRA_FLITS. On mismatch, set ctd_len_err (sticky until rst).
//  - Reassembly still consumes exactly 2+EXTRA_FLITS flits; there is no resync.
//  - A simulation-only $error is also issued.
//  Undefined: no comparison logic; ctd_len_err is tied 0.
// TESTING (build with CTRL_NOC1_DATA_W=64, EXTRA_W=96 -> EXTRA_FLITS=2, PADDING_W=32)
//  1. Basic message:
//     Stimulus: rte flit msg_len=3, dst x=2 y=1; misc flit src x=5 y=7;
//               extras 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_xxxx_xxxx.
//     Response: one wide flit, dst 2/1, src 5/7, msg_len=0, extra field=96'hAAAABBBBCCCCDDDD11112222, remaining bits 0.
//  2. Output backpressure:
//     Stimulus: hold dst_rdy=0 for 5 cycles in OUTPUT.
//     Response: dst_val=1 and stable data all 5 cycles; src_rdy=0; release -> flit taken, src_rdy=1 next cycle.
//  3. Input bubbles:
//     Stimulus: src_val toggled 1/0 every cycle across all 4 flits.
//     Response: identical output to test 1; dst_val rises 1 cycle after the 4th xfer.
//  4. Reset mid-message:
//     Stimulus: rst after rte+misc flits accepted, then a fresh 4-flit message.
//     Response: output equals the fresh message only; dst_val stays 0 before it.
//  5. Back-to-back messages:
//     Stimulus: 3 messages with src_val=1 and dst_rdy=1 throughout.
//     Response: 3 output flits spaced 5 cycles apart, in order, with correct payloads.
//  6. Length check (macro defined):
//     Stimulus: rte msg_len=4.
//     Response: ctd_len_err=1 from the next cycle and held; the output flit is still produced after 4 flits.
//     Same stimulus without the macro: ctd_len_err=0.

Source files
------------

// File: rtl/extra_hdr_noc_ctrl_to_data.sv
// Reassembles a routing/misc/extra ctrl-NoC message into one wide data-NoC header flit.
// Optional msg_len check against the expected flit count: define EXTRA_HDR_CTD_LEN_CHECK_EN.
module extra_hdr_noc_ctrl_to_data #(
    parameter int CTRL_NOC1_DATA_W = 64,
    parameter int NOC_DATA_WIDTH   = 512,
    parameter int EXTRA_W          = 96
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_noc_ctd_val,
    input  logic [CTRL_NOC1_DATA_W-1:0] src_noc_ctd_data,
    output logic                        noc_ctd_src_rdy,
    output logic                        noc_ctd_dst_val,
    output logic [NOC_DATA_WIDTH-1:0]   noc_ctd_dst_data,
    input  logic                        dst_noc_ctd_rdy,
    output logic                        ctd_len_err
);
    localparam int CW           = CTRL_NOC1_DATA_W;
    localparam int EXTRA_FLITS  = (EXTRA_W + CW - 1) / CW;
    localparam int SAVE_W       = EXTRA_FLITS * CW;
    localparam int PADDING_W    = SAVE_W - EXTRA_W;
    localparam int CNT_W        = (EXTRA_FLITS > 1) ? $clog2(EXTRA_FLITS) : 1;
    localparam int BASE_FLIT_W  = 2 * CW;
    // Flit layout from MSB: chip_id(14) x(8) y(8) fbits(4) msg_len/metadata(8) ...
    localparam int SRC_FIELDS_W = 34;
    localparam int MSG_LEN_W    = 8;
    localparam int MSG_LEN_MSB  = CW - SRC_FIELDS_W - 1;

    if (EXTRA_W <= 0) begin : g_bad_extra_w
        $error("EXTRA_W must be greater than 0");
    end
    if (CW < 64 || PADDING_W < 0 || PADDING_W >= CW) begin : g_bad_ctrl_w
        $error("CTRL_NOC1_DATA_W too narrow for the header layout");
    end
    if (BASE_FLIT_W + EXTRA_W > NOC_DATA_WIDTH) begin : g_bad_noc_w
        $error("extra field does not fit in the wide header flit");
    end

    typedef enum logic [1:0] {
        ST_RTE   = 2'd0,
        ST_MISC  = 2'd1,
        ST_EXTRA = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     rte_q, rte_d;
    logic [CW-1:0]     core_q, core_d;
    logic [SAVE_W-1:0] save_q, save_d, save_shift_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_rdy_q, src_rdy_d;
    logic              dst_val_q, dst_val_d;
    logic              xfer_s;

    assign xfer_s = src_noc_ctd_val & src_rdy_q;

    if (EXTRA_FLITS == 1) begin : g_single_extra
        assign save_shift_s = src_noc_ctd_data;
    end else begin : g_multi_extra
        assign save_shift_s = {save_q[SAVE_W-CW-1:0], src_noc_ctd_data};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RTE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RTE:   if (xfer_s) state_d = ST_MISC;  else state_d = ST_RTE;
            ST_MISC:  if (xfer_s) state_d = ST_EXTRA; else state_d = ST_MISC;
            ST_EXTRA: if (xfer_s && (cnt_q == CNT_W'(0))) state_d = ST_OUT; else state_d = ST_EXTRA;
            ST_OUT:   if (dst_noc_ctd_rdy) state_d = ST_RTE; else state_d = ST_OUT;
            default:  state_d = ST_RTE;
        endcase
    end

    // Handshake outputs decoded from the next state so they are registered with it
    always_comb begin
        src_rdy_d = 1'b1;
        dst_val_d = 1'b0;
        if (state_d == ST_OUT) begin
            src_rdy_d = 1'b0;
            dst_val_d = 1'b1;
        end else begin
            src_rdy_d = 1'b1;
            dst_val_d = 1'b0;
        end
    end

    // Header and extra-field collection
    always_comb begin
        rte_d  = rte_q;
        core_d = core_q;
        save_d = save_q;
        cnt_d  = cnt_q;
        case (state_q)
            ST_RTE: begin
                if (xfer_s) begin
                    rte_d = src_noc_ctd_data;
                    rte_d[MSG_LEN_MSB -: MSG_LEN_W] = '0;
                    cnt_d = CNT_W'(EXTRA_FLITS - 1);
                end else begin
                    rte_d = rte_q;
                end
            end
            ST_MISC: begin
                if (xfer_s) begin
                    core_d = {src_noc_ctd_data[CW-1 -: SRC_FIELDS_W], {(CW-SRC_FIELDS_W){1'b0}}};
                end else begin
                    core_d = core_q;
                end
            end
            ST_EXTRA: begin
                if (xfer_s) begin
                    save_d = save_shift_s;
                    cnt_d  = (cnt_q == CNT_W'(0)) ? cnt_q : cnt_q - CNT_W'(1);
                end else begin
                    save_d = save_q;
                end
            end
            ST_OUT:  cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rte_q     <= '0;
            core_q    <= '0;
            save_q    <= '0;
            cnt_q     <= '0;
            src_rdy_q <= 1'b1;
            dst_val_q <= 1'b0;
        end else begin
            rte_q     <= rte_d;
            core_q    <= core_d;
            save_q    <= save_d;
            cnt_q     <= cnt_d;
            src_rdy_q <= src_rdy_d;
            dst_val_q <= dst_val_d;
        end
    end

`ifdef EXTRA_HDR_CTD_LEN_CHECK_EN
    localparam logic [MSG_LEN_W-1:0] EXP_LEN = MSG_LEN_W'(1 + EXTRA_FLITS);
    logic len_err_q;
    logic len_bad_s;

    assign len_bad_s = (state_q == ST_RTE) && xfer_s &&
                       (src_noc_ctd_data[MSG_LEN_MSB -: MSG_LEN_W] != EXP_LEN);

    // Sticky msg_len mismatch flag; reassembly carries on regardless
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err_q <= 1'b0;
        end else if (len_bad_s) begin
            len_err_q <= 1'b1;
`ifndef SYNTHESIS
            $error("ctrl msg_len mismatch on routing flit");
`endif
        end else begin
            len_err_q <= len_err_q;
        end
    end

    assign ctd_len_err = len_err_q;
`else
    assign ctd_len_err = 1'b0;
`endif

    // Wide flit: routing | core src | extra field | zeros
    always_comb begin
        noc_ctd_dst_data = '0;
        noc_ctd_dst_data[NOC_DATA_WIDTH-1 -: CW]                = rte_q;
        noc_ctd_dst_data[NOC_DATA_WIDTH-CW-1 -: CW]             = core_q;
        noc_ctd_dst_data[NOC_DATA_WIDTH-BASE_FLIT_W-1 -: EXTRA_W] = save_q[SAVE_W-1 -: EXTRA_W];
    end

    assign noc_ctd_src_rdy = src_rdy_q;
    assign noc_ctd_dst_val = dst_val_q;

endmodule

// File: tb/tb_extra_hdr_noc_ctrl_to_data.sv
// Randomised and directed bench for extra_hdr_noc_ctrl_to_data against a queue-based header model.
module tb_extra_hdr_noc_ctrl_to_data;
    localparam int CW = 64;
    localparam int NW = 512;
    localparam int EW = 96;
`ifdef EXTRA_HDR_CTD_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_val;
    logic [CW-1:0] src_data;
    logic          src_rdy;
    logic          dst_val;
    logic [NW-1:0] dst_data;
    logic          dst_rdy;
    logic          len_err;

    extra_hdr_noc_ctrl_to_data #(.CTRL_NOC1_DATA_W(CW), .NOC_DATA_WIDTH(NW), .EXTRA_W(EW)) dut (
        .clk(clk), .rst(rst),
        .src_noc_ctd_val(src_val), .src_noc_ctd_data(src_data), .noc_ctd_src_rdy(src_rdy),
        .noc_ctd_dst_val(dst_val), .noc_ctd_dst_data(dst_data), .dst_noc_ctd_rdy(dst_rdy),
        .ctd_len_err(len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NW-1:0] exp_q[$];
    bit            len_err_exp = 1'b0;
    bit            rand_rdy = 1'b0;
    bit            rdy_fix = 1'b1;
    logic [NW-1:0] last_out = '0;
    int            acc_cyc[$];
    int            rise_cyc = -1;
    int            last_xfer_cyc = 0;
    logic          prev_val = 1'b0;

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wide header as the rules describe it: routing flit with msg_len cleared, src fields of
    // the misc flit (top 34 bits), then the top EW bits of the concatenated extras.
    function automatic logic [NW-1:0] model(input logic [CW-1:0] rte, input logic [CW-1:0] misc,
                                            input logic [CW-1:0] x0, input logic [CW-1:0] x1);
        logic [CW-1:0]  rte_m;
        logic [CW-1:0]  misc_m;
        logic [127:0]   e;
        rte_m  = rte & ~(64'hFF << 22);
        misc_m = misc & ~((64'd1 << 30) - 64'd1);
        e      = {x0, x1};
        return (NW'(rte_m) << 448) | (NW'(misc_m) << 384) | (NW'(e >> 32) << 288);
    endfunction

    // Downstream ready driver
    initial begin
        dst_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            dst_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("src_rdy", NW'(src_rdy), NW'(exp_q.size() == 0));
                check("dst_val", NW'(dst_val), NW'(exp_q.size() != 0));
                check("len_err", NW'(len_err), NW'(len_err_exp));
                if (dst_val && !prev_val) rise_cyc = cyc;
                if (dst_val && exp_q.size() != 0) begin
                    check("dst_data", dst_data, exp_q[0]);
                    if (dst_rdy) begin
                        last_out = dst_data;
                        acc_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
                prev_val = dst_val;
            end else begin
                prev_val = 1'b0;
            end
        end
    end

    task automatic do_reset();
        src_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        len_err_exp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_flit(input logic [CW-1:0] d, input bit bubble);
        int guard;
        bit ok;
        guard = 0;
        ok = 1'b0;
        if (bubble) begin
            src_val = 1'b0;
            @(posedge clk); #1;
        end
        src_val  = 1'b1;
        src_data = d;
        while (!ok) begin
            @(negedge clk);
            ok = src_rdy;
            last_xfer_cyc = cyc;
            @(posedge clk); #1;
            guard++;
            if (!ok && guard > 100) begin
                errors++;
                $display("FAIL send_timeout: src_rdy stuck low for %0d cycles, required 1", guard);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "input handshake stalled");
            end
        end
    endtask

    // mode: 0 no bubbles, 1 bubble before every flit, 2 random bubbles
    task automatic send_msg(input logic [CW-1:0] rte, input logic [CW-1:0] misc,
                            input logic [CW-1:0] x0, input logic [CW-1:0] x1,
                            input int mode, input bit hold);
        send_flit(rte, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
        if (LEN_CHK && rte[29:22] != 8'd3) len_err_exp = 1'b1;
        send_flit(misc, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
        send_flit(x0, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
        send_flit(x1, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
        exp_q.push_back(model(rte, misc, x0, x1));
        if (!hold) src_val = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d flits pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    localparam logic [CW-1:0] R1 = 64'h0000_0804_00C0_0000;  // dst x=2 y=1, msg_len=3
    localparam logic [CW-1:0] M1 = 64'h0000_141C_00C0_0000;  // src x=5 y=7, metadata=3
    localparam logic [CW-1:0] X0 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [CW-1:0] X1 = 64'h1111_2222_3333_4444;

    initial begin
        logic [NW-1:0] lit;
        logic [CW-1:0] r, m, a, b;
        int n0;
        lit = {64'h0000_0804_0000_0000, 64'h0000_141C_0000_0000,
               96'hAAAABBBBCCCCDDDD11112222, 288'd0};
        src_val  = 1'b0;
        src_data = '0;
        do_reset();
        @(negedge clk);
        check("rst_src_rdy", NW'(src_rdy), NW'(1'b1));
        check("rst_dst_val", NW'(dst_val), NW'(1'b0));
        check("rst_dst_data", dst_data, '0);
        check("rst_len_err", NW'(len_err), NW'(1'b0));
        @(posedge clk); #1;

        // Basic message
        check("model_lit", model(R1, M1, X0, X1), lit);
        send_msg(R1, M1, X0, X1, 0, 1'b0);
        wait_drain();
        check("t1_out", last_out, lit);
        check_int("t1_latency", rise_cyc - last_xfer_cyc, 1);

        // Output backpressure
        rdy_fix = 1'b0;
        send_msg(R1, M1, X1, X0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_val", NW'(dst_val), NW'(1'b1));
            check("t2_hold_src_rdy", NW'(src_rdy), NW'(1'b0));
            if (exp_q.size() != 0) check("t2_hold_data", dst_data, exp_q[0]);
        end
        rdy_fix = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_release_src_rdy", NW'(src_rdy), NW'(1'b1));
        check("t2_release_val", NW'(dst_val), NW'(1'b0));
        check("t2_out", last_out, model(R1, M1, X1, X0));
        @(posedge clk); #1;

        // Input bubbles
        send_msg(R1, M1, X0, X1, 1, 1'b0);
        wait_drain();
        check("t3_out", last_out, lit);
        check_int("t3_latency", rise_cyc - last_xfer_cyc, 1);

        // Reset mid-message
        n0 = acc_cyc.size();
        send_flit(64'h0000_0C08_00C0_0000, 1'b0);
        send_flit(64'h0000_2020_0000_0000, 1'b0);
        do_reset();
        send_msg(64'h0000_1008_00C0_0000, 64'h0000_0C0C_0000_0000,
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1'b0);
        wait_drain();
        check_int("t4_count", acc_cyc.size() - n0, 1);
        check("t4_out", last_out, model(64'h0000_1008_00C0_0000, 64'h0000_0C0C_0000_0000,
                                        64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210));

        // Back-to-back messages
        n0 = acc_cyc.size();
        send_msg(R1, M1, X0, X1, 0, 1'b1);
        send_msg(M1, R1, X1, X0, 0, 1'b1);
        send_msg(R1, R1, X0, X0, 0, 1'b0);
        wait_drain();
        check_int("t5_count", acc_cyc.size() - n0, 3);
        if (acc_cyc.size() >= n0 + 3) begin
            check_int("t5_gap1", acc_cyc[n0+1] - acc_cyc[n0], 5);
            check_int("t5_gap2", acc_cyc[n0+2] - acc_cyc[n0+1], 5);
        end
        check("t5_last", last_out, model(R1, R1, X0, X0));

        // Length mismatch (msg_len=4)
        send_msg(64'h0000_0804_0100_0000, M1, X0, X1, 0, 1'b0);
        wait_drain();
        @(negedge clk);
        check("t6_len_err", NW'(len_err), NW'(LEN_CHK));
        check("t6_out", last_out, lit);
        @(posedge clk); #1;
        do_reset();

        // Randomised traffic with random bubbles and backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            r = {$urandom, $urandom};
            r[29:22] = 8'd3;
            m = {$urandom, $urandom};
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send_msg(r, m, a, b, 2, 1'($urandom_range(0, 1)));
        end
        src_val = 1'b0;
        wait_drain();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
